// File: rtl/regset_sb.sv
// Register set with x0 hard-wired to zero, READ_PORTS combinational read ports, one write port, per-register busy scoreboard and a post-reset clear sweep.
// Optional macro REGSET_BYPASS_EN adds same-cycle write-through from the write port to the read ports.
module regset_sb #(
  parameter int REGISTER_COUNT = 32,
  parameter int XLEN           = 32,
  parameter int READ_PORTS     = 2,
  localparam int REG_W         = $clog2(REGISTER_COUNT)
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [XLEN-1:0]              write,
  input  logic [REG_W-1:0]             write_reg,
  input  logic                         write_enable,
  input  logic [READ_PORTS*REG_W-1:0]  q_reg,
  output logic [READ_PORTS*XLEN-1:0]   q,
  output logic [READ_PORTS-1:0]        q_busy,
  input  logic                         reserve_en,
  input  logic [REG_W-1:0]             reserve_reg,
  output logic                         ready
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [REG_W-1:0] LAST_IDX = REG_W'(REGISTER_COUNT - 1);
  localparam logic [REG_W-1:0] FIRST_IDX = REG_W'(1);

  state_t                    state_r;
  logic [REG_W-1:0]          clr_idx_r;
  logic                      ready_r;
  logic [REGISTER_COUNT-1:0] busy_r;
  logic [XLEN-1:0]           regs_r [REGISTER_COUNT];

  logic                      wr_hit_s;
  logic                      rsv_hit_s;
  logic [REG_W-1:0]          rd_idx_s [READ_PORTS];

  assign wr_hit_s  = (state_r == ST_RUN) && write_enable && (write_reg != '0);
  assign rsv_hit_s = (state_r == ST_RUN) && reserve_en && (reserve_reg != '0);
  assign ready     = ready_r;

  // Storage array: no reset on purpose, the sweep zeroes r1..rN-1 one per cycle.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      regs_r[clr_idx_r] <= '0;
    end else if (wr_hit_s) begin
      regs_r[write_reg] <= write;
    end
  end

  // Control FSM: clear sweep sequencing, ready flag and busy scoreboard.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= FIRST_IDX;
      ready_r   <= 1'b0;
      busy_r    <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_idx_r == LAST_IDX) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            clr_idx_r <= clr_idx_r + FIRST_IDX;
          end
        end
        ST_RUN: begin
          // Reserve is applied last: it belongs to a newer producer than the write.
          if (wr_hit_s) begin
            busy_r[write_reg] <= 1'b0;
          end
          if (rsv_hit_s) begin
            busy_r[reserve_reg] <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_idx_r <= FIRST_IDX;
          ready_r   <= 1'b0;
          busy_r    <= '0;
        end
      endcase
    end
  end

  // Per-port read index extraction.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_idx_s[p] = q_reg[p*REG_W +: REG_W];
    end
  end

  // Combinational read ports; x0 and the whole CLEAR phase read as zero.
  always_comb begin
    q      = '0;
    q_busy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if ((state_r == ST_RUN) && (rd_idx_s[p] != '0)) begin
        q[p*XLEN +: XLEN] = regs_r[rd_idx_s[p]];
        q_busy[p]         = busy_r[rd_idx_s[p]];
`ifdef REGSET_BYPASS_EN
        if (wr_hit_s && (rd_idx_s[p] == write_reg)) begin
          q[p*XLEN +: XLEN] = write;
          if (rsv_hit_s && (reserve_reg == write_reg)) begin
            q_busy[p] = busy_r[rd_idx_s[p]];
          end else begin
            q_busy[p] = 1'b0;
          end
        end else begin
          q[p*XLEN +: XLEN] = regs_r[rd_idx_s[p]];
        end
`endif
      end else begin
        q[p*XLEN +: XLEN] = '0;
        q_busy[p]         = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regset_sb.sv
// Bench for regset_sb: default instance (32x32, 2 ports) and a 16x64, 4-port instance, checked against a behavioural model every cycle.
module tb_regset_sb;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [63:0] wdata   [2];
  logic [4:0]  wreg    [2];
  logic        we      [2];
  logic        rsv_en  [2];
  logic [4:0]  rsv_reg [2];
  logic [4:0]  qr      [2][4];

  logic [63:0]  q_a;
  logic [1:0]   qb_a;
  logic         ready_a;
  logic [255:0] q_b;
  logic [3:0]   qb_b;
  logic         ready_b;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  logic [63:0] mregs  [2][32];
  logic        mbusy  [2][32];
  int          mcnt   [2];
  logic        mready [2];

  logic [63:0] b_vals [4] = '{64'h0000_0100_0000_0001, 64'h0000_0200_0000_0002,
                              64'h0000_0300_0000_0003, 64'h0000_0400_0000_0004};
  logic [4:0]  b_idx  [4] = '{5'd1, 5'd2, 5'd3, 5'd15};

  regset_sb #(.REGISTER_COUNT(32), .XLEN(32), .READ_PORTS(2)) dut_a (
    .clk(clk), .res(res), .write(wdata[0][31:0]), .write_reg(wreg[0]),
    .write_enable(we[0]), .q_reg({qr[0][1], qr[0][0]}), .q(q_a), .q_busy(qb_a),
    .reserve_en(rsv_en[0]), .reserve_reg(rsv_reg[0]), .ready(ready_a)
  );

  regset_sb #(.REGISTER_COUNT(16), .XLEN(64), .READ_PORTS(4)) dut_b (
    .clk(clk), .res(res), .write(wdata[1]), .write_reg(wreg[1][3:0]),
    .write_enable(we[1]), .q_reg({qr[1][3][3:0], qr[1][2][3:0], qr[1][1][3:0], qr[1][0][3:0]}),
    .q(q_b), .q_busy(qb_b), .reserve_en(rsv_en[1]), .reserve_reg(rsv_reg[1][3:0]), .ready(ready_b)
  );

  always #5 clk = ~clk;

  function automatic int nregs(int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int nports(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [63:0] xmask(int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] dut_q(int i, int p);
    if (i == 0) return {32'h0, q_a[p*32 +: 32]};
    return q_b[p*64 +: 64];
  endfunction

  function automatic logic dut_busy(int i, int p);
    return (i == 0) ? qb_a[p] : qb_b[p];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (nb < 0 && ready_b) nb = n;
      if (ready_a) begin
        na = n;
        break;
      end
    end
  endtask

  // Behavioural model: k-th edge after release zeroes register k; then writes/reserves.
  always @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < 2; i++) begin
        mcnt[i]   <= 0;
        mready[i] <= 1'b0;
        for (int r = 0; r < 32; r++) mbusy[i][r] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!mready[i]) begin
          mregs[i][mcnt[i] + 1] <= 64'h0;
          mcnt[i] <= mcnt[i] + 1;
          if (mcnt[i] + 1 == nregs(i) - 1) mready[i] <= 1'b1;
        end else begin
          if (we[i] && (int'(wreg[i]) % nregs(i)) != 0) begin
            mregs[i][int'(wreg[i]) % nregs(i)] <= wdata[i] & xmask(i);
            mbusy[i][int'(wreg[i]) % nregs(i)] <= 1'b0;
          end
          if (rsv_en[i] && (int'(rsv_reg[i]) % nregs(i)) != 0)
            mbusy[i][int'(rsv_reg[i]) % nregs(i)] <= 1'b1;
        end
      end
    end
  end

  // Compare process: every read port and ready of both instances on every falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d_ready", i), {63'h0, (i == 0) ? ready_a : ready_b}, {63'h0, mready[i]});
        for (int p = 0; p < nports(i); p++) begin
          int idx, w, r;
          logic [63:0] e;
          logic eb;
          idx = int'(qr[i][p]) % nregs(i);
          w   = int'(wreg[i]) % nregs(i);
          r   = int'(rsv_reg[i]) % nregs(i);
          e   = 64'h0;
          eb  = 1'b0;
          if (mready[i] && idx != 0) begin
            e  = mregs[i][idx];
            eb = mbusy[i][idx];
`ifdef REGSET_BYPASS_EN
            if (we[i] && w != 0 && w == idx) begin
              e = wdata[i] & xmask(i);
              if (!(rsv_en[i] && r == idx)) eb = 1'b0;
            end
`endif
          end
          check($sformatf("u%0d_q%0d", i, p), dut_q(i, p), e);
          check($sformatf("u%0d_busy%0d", i, p), {63'h0, dut_busy(i, p)}, {63'h0, eb});
        end
      end
    end
  end

  initial begin
    int na, nb;
    for (int i = 0; i < 2; i++) begin
      wdata[i] = 64'h0; wreg[i] = 5'd0; we[i] = 1'b0;
      rsv_en[i] = 1'b0; rsv_reg[i] = 5'd0;
      for (int p = 0; p < 4; p++) qr[i][p] = 5'd0;
    end
    #3 res = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) tick();

    // Sweep with traffic on unit 0 that must be ignored.
    we[0] = 1'b1; wreg[0] = 5'd4; wdata[0] = 64'hFFFF; rsv_en[0] = 1'b1; rsv_reg[0] = 5'd6;
    res = 1'b1;
    wait_ready(na, nb);
    we[0] = 1'b0; rsv_en[0] = 1'b0;
    check("sweep_edges_a", 64'(na), 64'd31);
    check("sweep_edges_b", 64'(nb), 64'd15);
    qr[0][0] = 5'd4; qr[0][1] = 5'd6;
    @(negedge clk);
    check("ignored_write", dut_q(0, 0), 64'h0);
    check("ignored_reserve", {63'h0, dut_busy(0, 1)}, 64'h0);
    for (int k = 1; k < 32; k++) begin
      tick();
      qr[0][0] = 5'(k); qr[0][1] = 5'(32 - k);
      @(negedge clk);
      check("cleared_read", dut_q(0, 0), 64'h0);
    end

    // Write r5, read r5 and r0.
    tick(); we[0] = 1'b1; wreg[0] = 5'd5; wdata[0] = 64'hDEADBEEF;
    tick(); we[0] = 1'b0; qr[0][0] = 5'd5; qr[0][1] = 5'd0;
    @(negedge clk);
    check("r5_read", dut_q(0, 0), 64'hDEADBEEF);
    check("r0_read", dut_q(0, 1), 64'h0);

    tick(); we[0] = 1'b1; wreg[0] = 5'd0; wdata[0] = 64'h12345678; qr[0][0] = 5'd0;
    tick(); we[0] = 1'b0;
    @(negedge clk);
    check("x0_write_dropped", dut_q(0, 0), 64'h0);

    // Scoreboard.
    tick(); rsv_en[0] = 1'b1; rsv_reg[0] = 5'd7;
    tick(); rsv_en[0] = 1'b0; qr[0][0] = 5'd7;
    @(negedge clk);
    check("r7_reserved", {63'h0, dut_busy(0, 0)}, 64'h1);
    tick(); we[0] = 1'b1; wreg[0] = 5'd7; wdata[0] = 64'h55;
    tick(); we[0] = 1'b0;
    @(negedge clk);
    check("r7_busy_cleared", {63'h0, dut_busy(0, 0)}, 64'h0);
    check("r7_data", dut_q(0, 0), 64'h55);
    tick(); we[0] = 1'b1; wreg[0] = 5'd9; wdata[0] = 64'hAA; rsv_en[0] = 1'b1; rsv_reg[0] = 5'd9;
    tick(); we[0] = 1'b0; rsv_en[0] = 1'b0; qr[0][0] = 5'd9;
    @(negedge clk);
    check("r9_data", dut_q(0, 0), 64'hAA);
    check("r9_busy", {63'h0, dut_busy(0, 0)}, 64'h1);

    // Same-cycle write visibility on port 1.
    tick(); we[0] = 1'b1; wreg[0] = 5'd3; wdata[0] = 64'h11111111;
    tick(); wdata[0] = 64'hCAFEF00D; qr[0][1] = 5'd3;
    @(negedge clk);
`ifdef REGSET_BYPASS_EN
    check("bypass_same_cycle", dut_q(0, 1), 64'hCAFEF00D);
`else
    check("no_bypass_same_cycle", dut_q(0, 1), 64'h11111111);
`endif
    tick(); we[0] = 1'b0;
    @(negedge clk);
    check("write_next_cycle", dut_q(0, 1), 64'hCAFEF00D);

    // Write plus reserve on busy r9 while reading it.
    tick(); we[0] = 1'b1; wreg[0] = 5'd9; wdata[0] = 64'hBB; rsv_en[0] = 1'b1; rsv_reg[0] = 5'd9;
    @(negedge clk);
    check("wr_rsv_busy_unforced", {63'h0, dut_busy(0, 0)}, 64'h1);
    tick(); we[0] = 1'b0; rsv_en[0] = 1'b0;
    @(negedge clk);
    check("r9_rewritten", dut_q(0, 0), 64'hBB);

    // 16x64, 4-port instance.
    for (int k = 0; k < 4; k++) begin
      tick(); we[1] = 1'b1; wreg[1] = b_idx[k]; wdata[1] = b_vals[k];
    end
    tick(); we[1] = 1'b0;
    for (int k = 0; k < 4; k++) qr[1][k] = b_idx[k];
    @(negedge clk);
    for (int k = 0; k < 4; k++) check($sformatf("b_port%0d", k), dut_q(1, k), b_vals[k]);

    // Mid-sweep reset.
    tick(); we[0] = 1'b1; wreg[0] = 5'd20; wdata[0] = 64'h1;
    tick(); we[0] = 1'b0; qr[0][0] = 5'd20; qr[0][1] = 5'd9;
    @(negedge clk);
    check("r20_prewritten", dut_q(0, 0), 64'h1);
    tick(); res = 1'b0;
    tick(); res = 1'b1;
    repeat (10) tick();
    res = 1'b0;
    #1;
    check("midsweep_ready_low", {63'h0, ready_a}, 64'h0);
    check("midsweep_busy_low", {62'h0, qb_a}, 64'h0);
    tick(); res = 1'b1;
    wait_ready(na, nb);
    check("resweep_edges_a", 64'(na), 64'd31);
    check("resweep_edges_b", 64'(nb), 64'd15);
    @(negedge clk);
    check("r20_cleared", dut_q(0, 0), 64'h0);
    check("r9_busy_cleared", {63'h0, dut_busy(0, 1)}, 64'h0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
